edp_normalize_sequencer: RTL and testbench
==========================================

# edp_normalize_sequencer

Multi-cycle normalization controller for the exact-dot-product (EDP) accumulator readout path. It accepts one wide fixed-point accumulator word and scans it chunk by chunk from the MSB, using per-2-bit-pair leading-zero codes to locate the first set bit. It then left-shifts the word so the leading one sits at the MSB, and returns the word with its leading-zero count. It sits between the EDP accumulator and the rounding/packing stage and time-multiplexes one CHUNK_WIDTH-wide leading-zero encoder slice across the full word.

## Interface
- DATA_WIDTH, 128, accumulator word width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 32, bits examined per scan cycle; must be even. NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH.
- CNT_WIDTH, $clog2(DATA_WIDTH+1), leading-zero count width.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  accumulator word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  normalized word (in_data << out_lzc).
- out_lzc  out  CNT_WIDTH  leading-zero count of in_data; DATA_WIDTH when zero.
- out_zero  out  1  in_data was all zeros.

## Operation
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, clear lzc, chunk index m=0 (MSB chunk = bits DATA_WIDTH-1 down to DATA_WIDTH-CHUNK_WIDTH), go to SCAN.
- SCAN, one chunk per cycle:
  - Encode each 2-bit pair of chunk m: 00→2, 01→1, 1x→0 leading zeros.
  - Chunk-local count = sum of codes of leading all-zero pairs, plus the code of the first nonzero pair.
  - Chunk all zero and m<NUM_CHUNKS-1: lzc+=CHUNK_WIDTH, m+=1, stay in SCAN.
  - Chunk all zero and m=NUM_CHUNKS-1: lzc=DATA_WIDTH, zero flag=1, go to DONE; no shift.
  - Chunk nonzero: lzc+=local count, go to SHIFT.
- SHIFT: data <= data << lzc (logical, zero fill). Go to DONE.
- DONE: out_valid=1; out_data, out_lzc and out_zero held stable. On out_ready, go to IDLE.
- One word in flight. in_ready=0 in SCAN, SHIFT and DONE. No acceptance in the DONE→IDLE handoff cycle.
- lzc never exceeds DATA_WIDTH. Chunk index does not wrap.

## Timing
- Reset (rst_n low, any state, including mid-scan): state=IDLE immediately. in_ready=1 after reset deassertion. out_valid=0, out_data=0, out_lzc=0, out_zero=0. In-flight word is discarded.
- Accept edge E0. First nonzero chunk index m: out_valid rises after edge E(m+2), i.e. latency m+2 cycles. Minimum 2 cycles, maximum NUM_CHUNKS+1 cycles.
- All-zero word: out_valid after edge E(NUM_CHUNKS).
- out_valid, once high, stays high with stable outputs until an out_ready edge. out_valid falls the cycle after that handshake.
- in_ready rises the cycle after the output handshake. Throughput: one word per latency+2 cycles.
- in_valid while in_ready=0 is ignored; the source must hold it.
- out_* registers hold the last result in IDLE. Only out_valid qualifies them.

## Test plan
- in_data=1<<127, out_ready=1 → out_lzc=0, out_data=1<<127, out_zero=0, out_valid 2 cycles after accept.
- in_data=128'h1 → out_lzc=127, out_data=1<<127, out_valid 5 cycles after accept (m=3).
- in_data=0 → out_zero=1, out_lzc=128, out_data=0, out_valid 4 cycles after accept.
- in_data=1<<78 (chunk 1 = 32'h0000_4000) → out_lzc=49, out_data=1<<127, latency 3. Also cover pair-code cases: in_data=1<<126 → lzc=1; in_data=3<<124 → lzc=2.
- Backpressure: out_ready=0 for 6 cycles after out_valid.
  - Required: outputs stable and in_ready=0 throughout.
  - After out_ready=1: out_valid drops, in_ready=1 next cycle, and the next word is processed correctly.
- rst_n pulsed low during SCAN of in_data=128'h1.
  - Required: all outputs at reset values asynchronously, no out_valid for the aborted word.
  - A new word then completes with correct lzc.

Source files
------------

// File: rtl/edp_normalize_sequencer_if.sv
// Handshake bundle between the EDP accumulator, the normalizer and the rounding stage.
// The slave modport is the normalizer's view; master is the surrounding source/consumer.
interface edp_normalize_sequencer_if #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  out_lzc;
    logic                  out_zero;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lzc, out_zero
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lzc, out_zero
    );
endinterface

// File: rtl/edp_normalize_sequencer.sv
// Multi-cycle leading-zero normalizer: scans the accumulator word one chunk per cycle from
// the MSB, then shifts the leading one to the MSB and reports the leading-zero count.
module edp_normalize_sequencer #(
    parameter int DATA_WIDTH  = 128,
    parameter int CHUNK_WIDTH = 32,
    parameter int CNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
    input logic                      clk,
    input logic                      rst_n,
    edp_normalize_sequencer_if.slave bus
);
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int NUM_PAIRS  = CHUNK_WIDTH / 2;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t                 state, state_d;
    logic [DATA_WIDTH-1:0]  data;
    logic [CNT_WIDTH-1:0]   lzc;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [CNT_WIDTH-1:0]   out_lzc_q;
    logic                   out_zero_q;

    logic [CHUNK_WIDTH-1:0] chunk;
    logic                   chunk_zero;
    logic [CNT_WIDTH-1:0]   local_cnt;
    logic                   found;
    logic [1:0]             pair;
    logic [1:0]             code;

    // Chunk selection and per-pair leading-zero encoding of the current chunk
    always_comb begin
        chunk     = '0;
        local_cnt = '0;
        found     = 1'b0;
        pair      = '0;
        code      = '0;
        for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
            if (IDX_W'(c) == idx)
                chunk = data[DATA_WIDTH-1-c*CHUNK_WIDTH -: CHUNK_WIDTH];
        end
        for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
            pair = chunk[CHUNK_WIDTH-1-2*p -: 2];
            if (pair == 2'b00)      code = 2'd2;
            else if (pair == 2'b01) code = 2'd1;
            else                    code = 2'd0;
            if (!found) begin
                local_cnt = local_cnt + CNT_WIDTH'(code);
                if (pair != 2'b00) found = 1'b1;
            end
        end
        chunk_zero = ~|chunk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = SCAN;
            end
            SCAN: begin
                if (!chunk_zero)          state_d = SHIFT;
                else if (idx == LAST_IDX) state_d = DONE;
            end
            SHIFT: state_d = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            lzc        <= '0;
            idx        <= '0;
            out_data_q <= '0;
            out_lzc_q  <= '0;
            out_zero_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data <= bus.in_data;
                        lzc  <= '0;
                        idx  <= '0;
                    end
                end
                SCAN: begin
                    if (!chunk_zero) begin
                        lzc <= lzc + local_cnt;
                    end else if (idx == LAST_IDX) begin
                        lzc        <= CNT_WIDTH'(DATA_WIDTH);
                        out_data_q <= '0;
                        out_lzc_q  <= CNT_WIDTH'(DATA_WIDTH);
                        out_zero_q <= 1'b1;
                    end else begin
                        lzc <= lzc + CNT_WIDTH'(CHUNK_WIDTH);
                        idx <= idx + 1'b1;
                    end
                end
                SHIFT: begin
                    // Result registers are separate from the working word so they hold across IDLE
                    data       <= data << lzc;
                    out_data_q <= data << lzc;
                    out_lzc_q  <= lzc;
                    out_zero_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_lzc  = out_lzc_q;
    assign bus.out_zero = out_zero_q;
endmodule

// File: tb/tb_edp_normalize_sequencer.sv
// Bench for edp_normalize_sequencer: directed and random words against a bit-scan model.
module tb_edp_normalize_sequencer;
    localparam int DW = 128;
    localparam int CW = 32;
    localparam int NW = 8;
    localparam int NC = DW / CW;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   fails   = 0;

    edp_normalize_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(NW)) bus ();

    edp_normalize_sequencer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_lzc(input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--)
            if (d[i]) return DW - 1 - i;
        return DW;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w >> $urandom_range(0, DW);
    endfunction

    task automatic run_word(input logic [DW-1:0] d, input int bp);
        int lz, lat, exp_lat;
        logic [DW-1:0] exp_data;
        lz       = ref_lzc(d);
        exp_data = (lz == DW) ? '0 : d << lz;
        exp_lat  = (lz == DW) ? NC : lz / CW + 2;

        @(negedge clk);
        check("in_ready_idle", DW'(bus.in_ready), DW'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.in_data = $urandom;

        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 3 * NC) begin
            @(negedge clk);
            lat++;
        end
        check("latency", DW'(lat), DW'(exp_lat));
        check("out_data", bus.out_data, exp_data);
        check("out_lzc", DW'(bus.out_lzc), DW'(lz));
        check("out_zero", DW'(bus.out_zero), DW'(lz == DW));

        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_valid", DW'(bus.out_valid), DW'(1));
            check("bp_ready", DW'(bus.in_ready), DW'(0));
            check("bp_data", bus.out_data, exp_data);
            check("bp_lzc", DW'(bus.out_lzc), DW'(lz));
        end

        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("valid_drop", DW'(bus.out_valid), DW'(0));
        check("ready_rise", DW'(bus.in_ready), DW'(1));
        check("idle_hold_data", bus.out_data, exp_data);
        check("idle_hold_lzc", DW'(bus.out_lzc), DW'(lz));
    endtask

    initial begin
        logic [DW-1:0] w;
        int bad_valid;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", DW'(bus.out_valid), DW'(0));
        check("rst_data", bus.out_data, '0);
        check("rst_lzc", DW'(bus.out_lzc), DW'(0));
        check("rst_zero", DW'(bus.out_zero), DW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));

        w = '0; w[127] = 1'b1;       run_word(w, 0);
        w = 128'h1;                  run_word(w, 0);
        w = '0;                      run_word(w, 0);
        w = '0; w[78] = 1'b1;        run_word(w, 0);
        w = '0; w[126] = 1'b1;       run_word(w, 1);
        w = '0; w[125:124] = 2'b11;  run_word(w, 0);
        w = {$urandom, $urandom, $urandom, $urandom} | 128'h1; w[127:32] = '0;
        run_word(w, 6);
        w = rand_word();             run_word(w, 0);

        // Asynchronous reset in the middle of scanning a word that needs the full scan
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", DW'(bus.out_valid), DW'(0));
        check("arst_ready", DW'(bus.in_ready), DW'(1));
        check("arst_data", bus.out_data, '0);
        check("arst_lzc", DW'(bus.out_lzc), DW'(0));
        check("arst_zero", DW'(bus.out_zero), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bad_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) bad_valid++;
        end
        check("aborted_no_valid", DW'(bad_valid), DW'(0));
        w = '0; w[100] = 1'b1;       run_word(w, 0);

        for (int n = 0; n < 24; n++) begin
            w = rand_word();
            run_word(w, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
